mips_multicycle_ctrl: RTL

//  Main control FSM of the multicycle MIPS core; sits directly upstream of the ALU decoder and drives its
//  2-bit aluop plus all datapath enables/selects. Sequences fetch/decode/execute/memory/writeback per opcode.

---
 rtl/mips_multicycle_ctrl_pkg.sv | 75 +++++++
 rtl/mips_multicycle_ctrl_if.sv | 40 ++++
 rtl/mips_multicycle_ctrl_outdec.sv | 90 +++++++++
 rtl/mips_multicycle_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller and the ALU decoder.
// Optional feature macro: MIPS_CTRL_IMM_JUMP_EN (adds addi and j support).
package mips_ctrl_pkg;

    // Controller states. Without MIPS_CTRL_IMM_JUMP_EN, ADDIEXEC/ADDIWB/JUMP are never entered
    // and their encodings are treated like any other unreachable encoding.
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_e;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // aluop encoding seen by the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Complete control word produced each cycle by the output decoder
    typedef struct packed {
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic [1:0] aluop;
        logic       illegal_op;
    } ctrl_word_t;

    // True when the controller has a sequence for this opcode in the current build
    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ: ok = 1'b1;
`ifdef MIPS_CTRL_IMM_JUMP_EN
            OP_ADDI, OP_J:                  ok = 1'b1;
`endif
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: opcode/flag/memory-ready inputs and all control strobes.
// master = controller side, slave = datapath/memory side.
// Handshake: the controller keeps a memory access state (and its strobes) asserted every cycle
// until mem_rdy is sampled high on a rising edge; that edge completes the access.
interface mips_multicycle_ctrl_if
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic             zero;
    logic             mem_rdy;
    logic             memwrite;
    logic             irwrite;
    logic             regwrite;
    logic             iord;
    logic             memtoreg;
    logic             regdst;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       pcsrc;
    logic             pcen;
    logic [1:0]       aluop;
    logic             illegal_op;
    logic             err_sticky;
    logic [CNT_W-1:0] instr_cnt;
    state_e           dbg_state;

    modport master (
        input  op, zero, mem_rdy,
        output memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
               alusrcb, pcsrc, pcen, aluop, illegal_op, err_sticky, instr_cnt, dbg_state
    );

    modport slave (
        output op, zero, mem_rdy,
        input  memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
               alusrcb, pcsrc, pcen, aluop, illegal_op, err_sticky, instr_cnt, dbg_state
    );
endinterface

// File: rtl/mips_multicycle_ctrl_outdec.sv
// Combinational state -> control word decode for the multicycle MIPS controller.
// Optional feature macro: MIPS_CTRL_IMM_JUMP_EN (decodes ADDIEXEC/ADDIWB/JUMP).
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_e     i_state,
    input  logic [5:0] i_op,
    input  logic       i_mem_rdy,
    input  logic       i_zero,
    output ctrl_word_t o_cw
);
    logic w_pcwrite;
    logic w_branch;

    // Moore decode of the current state; FETCH strobes are gated by mem_rdy, branch by zero
    always_comb begin
        o_cw      = '0;
        w_pcwrite = 1'b0;
        w_branch  = 1'b0;
        case (i_state)
            FETCH: begin
                o_cw.iord    = 1'b0;
                o_cw.alusrca = 1'b0;
                o_cw.alusrcb = SRCB_FOUR;
                o_cw.aluop   = ALUOP_ADD;
                o_cw.pcsrc   = PCSRC_ALU;
                o_cw.irwrite = i_mem_rdy;
                w_pcwrite    = i_mem_rdy;
            end
            DECODE: begin
                o_cw.alusrcb    = SRCB_IMM_SH;
                o_cw.aluop      = ALUOP_ADD;
                o_cw.illegal_op = ~op_supported(i_op);
            end
            MEMADR: begin
                o_cw.alusrca = 1'b1;
                o_cw.alusrcb = SRCB_IMM;
                o_cw.aluop   = ALUOP_ADD;
            end
            MEMRD: begin
                o_cw.iord = 1'b1;
            end
            MEMWB: begin
                o_cw.regwrite = 1'b1;
                o_cw.memtoreg = 1'b1;
                o_cw.regdst   = 1'b0;
            end
            MEMWR: begin
                o_cw.iord     = 1'b1;
                o_cw.memwrite = 1'b1;
            end
            EXECUTE: begin
                o_cw.alusrca = 1'b1;
                o_cw.alusrcb = SRCB_RT;
                o_cw.aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                o_cw.regwrite = 1'b1;
                o_cw.regdst   = 1'b1;
                o_cw.memtoreg = 1'b0;
            end
            BRANCH: begin
                o_cw.alusrca = 1'b1;
                o_cw.alusrcb = SRCB_RT;
                o_cw.aluop   = ALUOP_SUB;
                o_cw.pcsrc   = PCSRC_ALUOUT;
                w_branch     = 1'b1;
            end
`ifdef MIPS_CTRL_IMM_JUMP_EN
            ADDIEXEC: begin
                o_cw.alusrca = 1'b1;
                o_cw.alusrcb = SRCB_IMM;
                o_cw.aluop   = ALUOP_ADD;
            end
            ADDIWB: begin
                o_cw.regwrite = 1'b1;
                o_cw.regdst   = 1'b0;
            end
            JUMP: begin
                o_cw.pcsrc = PCSRC_JUMP;
                w_pcwrite  = 1'b1;
            end
`endif
            default: begin
                // unreachable encodings: every strobe stays low
            end
        endcase
        o_cw.pcen = w_pcwrite | (w_branch & i_zero);
    end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: state register, next-state logic,
// retired-instruction counter and sticky illegal-opcode flag.
// Optional feature macro: MIPS_CTRL_IMM_JUMP_EN (adds addi and j instruction sequences).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input logic                    clk,
    input logic                    rst_n,
    mips_multicycle_ctrl_if.master bus
);
    state_e           r_state;
    state_e           w_next;
    logic             w_retire;
    logic [CNT_W-1:0] r_instr_cnt;
    logic             r_err_sticky;
    ctrl_word_t       w_cw;

    mips_ctrl_outdec u_outdec (
        .i_state   (r_state),
        .i_op      (bus.op),
        .i_mem_rdy (bus.mem_rdy),
        .i_zero    (bus.zero),
        .o_cw      (w_cw)
    );

    // Next-state selection; the opcode is held stable by the instruction register after FETCH
    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:   w_next = bus.mem_rdy ? DECODE : FETCH;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYPE:     w_next = EXECUTE;
                    OP_BEQ:       w_next = BRANCH;
`ifdef MIPS_CTRL_IMM_JUMP_EN
                    OP_ADDI:      w_next = ADDIEXEC;
                    OP_J:         w_next = JUMP;
`endif
                    default:      w_next = FETCH;
                endcase
            end
            MEMADR:  w_next = (bus.op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   w_next = bus.mem_rdy ? MEMWB : MEMRD;
            MEMWB:   w_next = FETCH;
            MEMWR:   w_next = bus.mem_rdy ? FETCH : MEMWR;
            EXECUTE: w_next = ALUWB;
            ALUWB:   w_next = FETCH;
            BRANCH:  w_next = FETCH;
`ifdef MIPS_CTRL_IMM_JUMP_EN
            ADDIEXEC: w_next = ADDIWB;
            ADDIWB:   w_next = FETCH;
            JUMP:     w_next = FETCH;
`endif
            default: w_next = FETCH;
        endcase
    end

    // An instruction retires on its final transition back to FETCH (illegal returns excluded)
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            MEMWB, ALUWB, BRANCH: w_retire = 1'b1;
            MEMWR:                w_retire = bus.mem_rdy;
`ifdef MIPS_CTRL_IMM_JUMP_EN
            ADDIWB, JUMP:         w_retire = 1'b1;
`endif
            default:              w_retire = 1'b0;
        endcase
    end

    // State register, wrapping retire counter and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FETCH;
            r_instr_cnt  <= '0;
            r_err_sticky <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_instr_cnt <= r_instr_cnt + 1'b1;
            end
            if (w_cw.illegal_op) begin
                r_err_sticky <= 1'b1;
            end
        end
    end

    assign bus.memwrite   = w_cw.memwrite;
    assign bus.irwrite    = w_cw.irwrite;
    assign bus.regwrite   = w_cw.regwrite;
    assign bus.iord       = w_cw.iord;
    assign bus.memtoreg   = w_cw.memtoreg;
    assign bus.regdst     = w_cw.regdst;
    assign bus.alusrca    = w_cw.alusrca;
    assign bus.alusrcb    = w_cw.alusrcb;
    assign bus.pcsrc      = w_cw.pcsrc;
    assign bus.pcen       = w_cw.pcen;
    assign bus.aluop      = w_cw.aluop;
    assign bus.illegal_op = w_cw.illegal_op;
    assign bus.err_sticky = r_err_sticky;
    assign bus.instr_cnt  = r_instr_cnt;
    assign bus.dbg_state  = r_state;
endmodule
